core_ctrl: RTL and testbench

- Instruction sequencer sitting directly upstream of the core (row x col systolic array + xMem + psumMem).
- Generates the 35-bit `inst` word, one registered value per cycle, for a single kernel pass (one kij):
  - weight fetch → L0 → array load
  - activation fetch → L0 → execute
  - OFIFO drain into psum memory
- Consumes core `valid`. Reports `busy`/`done` to the host or testbench.
- The host preloads xMem with activations and weights before pulsing `start`.

---
 rtl/core_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_core_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// Single-kernel-pass instruction sequencer for the systolic core.
// Optional DRAIN stall counter enabled with `define CORE_CTRL_PERF_EN.
module core_ctrl #(
  parameter int row       = 8,
  parameter int col       = 8,
  parameter int len_nij   = 36,
  parameter int act_base  = 0,
  parameter int wgt_base  = 1024,
  parameter int psum_base = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  kij,
  input  logic        mode,
  input  logic        valid,
  output logic [34:0] inst,
  output logic        busy,
  output logic        done
`ifdef CORE_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_WFETCH, S_WLOAD, S_WPROP, S_XFETCH, S_EXEC, S_DRAIN, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] drn_q, drn_d;
  logic [3:0]  kij_q, kij_d;
  logic        mode_q, mode_d;
  logic        valid_q;
  logic [34:0] inst_q, inst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [10:0] wgt_addr, act_addr, psum_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    drn_d   = drn_q;
    kij_d   = kij_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_WFETCH;
          kij_d   = kij;
          mode_d  = mode;
          drn_d   = '0;
        end
      end
      S_WFETCH: if (cnt_q == 16'(col - 1)) begin
        state_d = S_WLOAD;
        cnt_d   = '0;
      end
      S_WLOAD: if (cnt_q == 16'(col - 1)) begin
        state_d = S_WPROP;
        cnt_d   = '0;
      end
      S_WPROP: if (cnt_q == 16'(row - 1)) begin
        state_d = S_XFETCH;
        cnt_d   = '0;
      end
      S_XFETCH: if (cnt_q == 16'(len_nij - 1)) begin
        state_d = S_EXEC;
        cnt_d   = '0;
      end
      S_EXEC: if (cnt_q == 16'(len_nij - 1)) begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end
      S_DRAIN: begin
        cnt_d = '0;
        if (inst_q[6]) drn_d = drn_q + 16'd1;
        if (drn_d == 16'(len_nij)) state_d = S_DONE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Instruction word is built from the next state so it lines up with state_q.
  assign wgt_addr  = 11'(wgt_base) + 11'(kij_d) * 11'(col) + 11'(cnt_d);
  assign act_addr  = 11'(act_base) + 11'(cnt_d);
  assign psum_addr = 11'(psum_base) + 11'(kij_d) * 11'(len_nij) + 11'(drn_d);

  always_comb begin
    inst_d     = IDLE_INST;
    inst_d[34] = mode_d;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    // One-cycle xMem read latency: the L0 write trails each fetch cycle.
    inst_d[2]  = (state_q == S_WFETCH) || (state_q == S_XFETCH);
    case (state_d)
      S_IDLE: begin
        inst_d = IDLE_INST;
        busy_d = 1'b0;
      end
      S_DONE: begin
        inst_d = IDLE_INST;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      S_WFETCH: begin
        inst_d[19]   = 1'b0;
        inst_d[17:7] = wgt_addr;
      end
      S_WLOAD: begin
        inst_d[3] = 1'b1;
        inst_d[0] = 1'b1;
      end
      S_XFETCH: begin
        inst_d[19]   = 1'b0;
        inst_d[17:7] = act_addr;
      end
      S_EXEC: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      S_DRAIN: if (valid && (drn_d < 16'(len_nij))) begin
        inst_d[6]     = 1'b1;
        inst_d[32]    = 1'b0;
        inst_d[31]    = 1'b0;
        inst_d[30:20] = psum_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
      kij_q   <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= IDLE_INST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      kij_q   <= kij_d;
      mode_q  <= mode_d;
      valid_q <= valid;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef CORE_CTRL_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) stall_d = '0;
    else if ((state_q == S_DRAIN) && !inst_q[6] && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  // valid_q only documents the drain timing; the registered copy is implied by inst_d.
  logic unused_valid_q;
  assign unused_valid_q = valid_q;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized bench for core_ctrl against a cycle-numbered model of one kernel pass.
// Checks stall_cnt as well when CORE_CTRL_PERF_EN is defined.
module tb_core_ctrl;
  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  kij = '0;
  logic        mode = 1'b0;
  logic        valid = 1'b0;
  logic [34:0] inst;
  logic        busy, done;
`ifdef CORE_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .kij   (kij),
    .mode  (mode),
    .valid (valid),
    .inst  (inst),
    .busy  (busy),
    .done  (done)
`ifdef CORE_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // valid stimulus: 0 tied high, 1 random, 2 random then 1,1,0,0 from drain, 3 five low drain cycles
  function automatic logic vfun(input int vm, input int t);
    case (vm)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      2:       return (t < 96) ? 1'($urandom_range(0, 1)) : (((t - 96) % 4) < 2);
      default: return !((t >= 96) && (t <= 100));
    endcase
  endfunction

  // Cycle 0 is the cycle start is high; cycle t is the t-th cycle after acceptance.
  task automatic run_pass(input logic [3:0] k, input logic m, input int vm, input bit poke);
    logic        vh [0:1023];
    logic [34:0] w;
    int          d = 0, stalls = 0, n_exec = 0, n_wr = 0, n_done = 0, t_done = -1;
    bit          fin = 0;
    @(posedge clk); #1;
    start = 1'b1; kij = k; mode = m;
    valid = vfun(vm, 0); vh[0] = valid;
    for (int t = 1; t < 1024 && !fin; t++) begin
      @(posedge clk); #1;
      start = poke && (t == 70);
      if (start) begin kij = ~k; mode = ~m; end
      valid = vfun(vm, t); vh[t] = valid;
      @(negedge clk);
      w = IDLE_W;
      w[34] = m;
      if (t <= 8) begin
        w[19] = 1'b0;
        w[17:7] = 11'(1024 + int'(k) * 8 + (t - 1));
        w[2] = (t >= 2);
      end else if (t <= 16) begin
        w[3] = 1'b1; w[0] = 1'b1; w[2] = (t == 9);
      end else if (t <= 24) begin
        w = w;
      end else if (t <= 60) begin
        w[19] = 1'b0;
        w[17:7] = 11'(t - 25);
        w[2] = (t >= 26);
      end else if (t <= 96) begin
        w[3] = 1'b1; w[1] = 1'b1; w[2] = (t == 61);
      end else if (d < 36) begin
        if (vh[t - 1]) begin
          w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0;
          w[30:20] = 11'(int'(k) * 36 + d);
          d++;
        end else stalls++;
      end else begin
        w = IDLE_W;
        fin = 1;
      end
      check($sformatf("inst k=%0d t=%0d", k, t), inst, w);
      check($sformatf("busy,done t=%0d", t), 35'({busy, done}), 35'({!fin, fin}));
`ifdef CORE_CTRL_PERF_EN
      if (t == 1) check("stall_cnt cleared on start", 35'(stall_cnt), 35'd0);
      if (fin) check("stall_cnt at done", 35'(stall_cnt), 35'(stalls));
`endif
      n_exec += int'(inst[1]);
      n_wr   += int'(!inst[32] && !inst[31]);
      if (done) begin n_done++; t_done = t; end
    end
    check("pass finished in budget", 35'(fin), 35'd1);
    check("execute cycles", 35'(n_exec), 35'd36);
    check("psum writes", 35'(n_wr), 35'd36);
    check("done pulses", 35'(n_done), 35'd1);
    if (vm == 0) check("start-to-done cycles", 35'(t_done), 35'd133);
    repeat (3) begin
      @(posedge clk); #1;
      valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle after done inst", inst, IDLE_W);
      check("idle after done busy,done", 35'({busy, done}), 35'd0);
`ifdef CORE_CTRL_PERF_EN
      check("stall_cnt holds", 35'(stall_cnt), 35'(stalls));
`endif
    end
  endtask

  task automatic reset_mid_pass();
    int n_done = 0;
    @(posedge clk); #1;
    start = 1'b1; kij = 4'd3; mode = 1'b1; valid = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("async reset inst", inst, IDLE_W);
    check("async reset busy", 35'(busy), 35'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int t = 0; t < 150; t++) begin
      @(negedge clk);
      n_done += int'(done);
    end
    check("no done after reset", 35'(n_done), 35'd0);
    check("idle after reset inst", inst, IDLE_W);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset inst", inst, IDLE_W);
    check("reset busy,done", 35'({busy, done}), 35'd0);
    @(posedge clk); #1 reset = 1'b1;

    run_pass(4'd2, 1'b0, 0, 1'b0);
    run_pass(4'd0, 1'b0, 0, 1'b0);
    run_pass(4'($urandom_range(0, 8)), 1'b0, 2, 1'b0);
    run_pass(4'd5, 1'b1, 0, 1'b1);
    for (int i = 0; i < 3; i++)
      run_pass(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1, 1'b0);
    run_pass(4'd1, 1'b0, 3, 1'b0);
    reset_mid_pass();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
